pe_mac_sequencer: RTL and testbench
===================================

# pe_mac_sequencer

Sequencer for a single PE multiply-accumulate datapath. It accepts a dot-product job of `cfg_len` terms and issues IFM/weight buffer reads. It drives the PE clear/enable strobes aligned to the one-cycle buffer read latency, then captures the PE accumulator. The accumulator is requantized (rounding arithmetic shift plus saturation) and returned as an 8-bit OFM value over a valid/ready handshake. It sits between the layer controller and the PE/buffer pair.

## Interface
- `ADDR_W`, 10, buffer address width
- `LEN_W`, 10, job length width
- `ACC_W`, 20, PE accumulator width (signed)
- `OUT_W`, 8, OFM output width (signed)

- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  job request, sampled in IDLE only
- `cfg_len`  in  LEN_W  number of MAC terms, valid range 1..2^LEN_W-1
- `cfg_ifm_base`  in  ADDR_W  first IFM address
- `cfg_wgt_base`  in  ADDR_W  first weight address
- `cfg_shift`  in  4  requantization right shift, 0..15
- `busy`  out  1  high whenever state != IDLE
- `rd_en`  out  1  buffer read strobe; data returns the next cycle
- `ifm_addr`  out  ADDR_W  IFM read address
- `wgt_addr`  out  ADDR_W  weight read address
- `pe_clear`  out  1  synchronous accumulator clear to PE
- `pe_en`  out  1  PE accumulate enable
- `pe_acc`  in  ACC_W  PE accumulator value (signed)
- `ofm_data`  out  OUT_W  requantized result
- `ofm_valid`  out  1  result valid
- `ofm_ready`  in  1  downstream accepts result
- `done`  out  1  single-cycle pulse after result handshake

## Operation
- FSM states: IDLE, FETCH, WAIT, CAPTURE, OUT.
- IDLE → FETCH on `start`=1 with `cfg_len`≠0. All `cfg_*` are latched on that edge.
- `start` with `cfg_len`=0 is ignored. `start` outside IDLE is ignored.
- FETCH: `rd_en`=1 for exactly `cfg_len` cycles. Term i uses `ifm_addr`=`ifm_base`+i and `wgt_addr`=`wgt_base`+i, mod 2^ADDR_W (wrap-around is legal). On the last term the FSM goes to WAIT.
- `pe_clear`=1 in the first FETCH cycle only.
- `pe_en` = `rd_en` delayed one cycle, so it is high for `cfg_len` cycles starting in the second FETCH cycle.
- WAIT: one cycle, during which the last `pe_en` is high. Then CAPTURE.
- CAPTURE: one cycle. `pe_acc` is sampled and `ofm_data` is registered. Then OUT.
- Requantization (internal width ACC_W+1, no overflow):
  - r = `pe_acc` + (`cfg_shift`>0 ? 1<<(`cfg_shift`-1) : 0)
  - r = r >>> `cfg_shift` (arithmetic shift)
  - saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
- OUT: `ofm_valid`=1, and `ofm_data` is held stable until `ofm_ready`=1. The handshake edge returns the FSM to IDLE, and `done`=1 in the following cycle.
- `ofm_ready` outside OUT has no effect.

## Timing
- Reset values: `busy`, `rd_en`, `pe_clear`, `pe_en`, `ofm_valid`, `done` = 0. `ifm_addr`, `wgt_addr`, `ofm_data` = 0. State is IDLE.
- Cycle numbering, with the start edge = cycle 0:
  - FETCH spans cycles 1..L; `rd_en` is high in cycles 1..L.
  - `pe_clear` is high in cycle 1.
  - `pe_en` is high in cycles 2..L+1.
  - WAIT = cycle L+1, CAPTURE = cycle L+2.
  - `ofm_valid` rises in cycle L+3.
- With `ofm_ready` held high, `done` is high in cycle L+4. The earliest next `start` is accepted in cycle L+4.
- `busy` is high from cycle 1 through the handshake cycle inclusive.
- Reset asserted mid-job forces the reset values immediately (asynchronously). The in-flight result is discarded and no `done` is issued.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- `PE_SEQ_RELU_EN`:
  - Defined: ReLU is applied after saturation, so negative results become 0 and the output range is [0, 2^(OUT_W-1)-1].
  - Undefined: the signed saturated value is output unchanged.

## Test plan
- Basic job, L=4, bases 0x010 and 0x200, shift 0, `ofm_ready`=1:
  - `rd_en` is high in cycles 1-4; addresses step 0x010..0x013 and 0x200..0x203.
  - `pe_en` is high in cycles 2-5.
  - `pe_acc`=37 gives `ofm_data`=37 at cycle 7, and `done` is high at cycle 8.
- Rounding and saturation:
  - `pe_acc`=5, shift 1 → 3.
  - `pe_acc`=-5, shift 1 → -2.
  - `pe_acc`=1000, shift 2 → 127.
  - `pe_acc`=-3000, shift 0 → -128; with `PE_SEQ_RELU_EN` defined → 0.
- Backpressure: `ofm_ready` held low for 5 cycles after `ofm_valid` → `ofm_data` is stable, `busy`=1, and `start` pulses are ignored. `done` fires one cycle after `ofm_ready` rises.
- Address wrap: base 0x3FE, L=4 → addresses 0x3FE, 0x3FF, 0x000, 0x001.
- Boundary starts:
  - `start` with `cfg_len`=0 → no state change and `busy` stays 0.
  - L=1 → `rd_en` in cycle 1 only, `pe_en` in cycle 2 only, `ofm_valid` at cycle 4.
- Reset mid-FETCH at cycle 3 of an L=8 job → all outputs are 0 immediately. A new job after deassertion runs with the full, correct timing.

Source files
------------

// File: rtl/pe_mac_sequencer.sv
// Sequencer for one PE multiply-accumulate datapath: it issues buffer reads, strobes the PE,
// requantizes the accumulator and hands the OFM byte downstream. Optional ReLU: PE_SEQ_RELU_EN.
module pe_mac_sequencer #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 10,
  parameter int ACC_W  = 20,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [ADDR_W-1:0] cfg_ifm_base,
  input  logic [ADDR_W-1:0] cfg_wgt_base,
  input  logic [3:0]        cfg_shift,
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] ifm_addr,
  output logic [ADDR_W-1:0] wgt_addr,
  output logic              pe_clear,
  output logic              pe_en,
  input  logic [ACC_W-1:0]  pe_acc,
  output logic [OUT_W-1:0]  ofm_data,
  output logic              ofm_valid,
  input  logic              ofm_ready,
  output logic              done
);

  // Output handshake: a result transfers on the rising edge where ofm_valid and ofm_ready
  // are both high; ofm_data is held stable while ofm_valid waits for ofm_ready.

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_OUT     = 3'd4
  } state_t;

  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 <<< (OUT_W-1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(1 <<< (OUT_W-1)));

  state_t             state;
  logic [LEN_W-1:0]   remain;
  logic [3:0]         shift_q;

  logic signed [ACC_W:0] acc_ext;
  logic signed [ACC_W:0] rnd;
  logic signed [ACC_W:0] r_sum;
  logic signed [ACC_W:0] r_shr;
  logic [OUT_W-1:0]      quant;

  // One extra bit of headroom so the rounding add can never overflow.
  always_comb begin
    acc_ext = $signed({pe_acc[ACC_W-1], pe_acc});
    rnd     = '0;
    if (shift_q != 4'd0) rnd = (ACC_W+1)'(1) << (shift_q - 4'd1);
    r_sum   = acc_ext + rnd;
    r_shr   = r_sum >>> shift_q;
    if (r_shr > SAT_MAX)      quant = SAT_MAX[OUT_W-1:0];
    else if (r_shr < SAT_MIN) quant = SAT_MIN[OUT_W-1:0];
    else                      quant = r_shr[OUT_W-1:0];
`ifdef PE_SEQ_RELU_EN
    if (quant[OUT_W-1]) quant = '0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      remain    <= '0;
      shift_q   <= '0;
      busy      <= 1'b0;
      rd_en     <= 1'b0;
      ifm_addr  <= '0;
      wgt_addr  <= '0;
      pe_clear  <= 1'b0;
      pe_en     <= 1'b0;
      ofm_data  <= '0;
      ofm_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done     <= 1'b0;
      pe_clear <= 1'b0;
      // Buffer data lands one cycle after the read strobe, so the PE enable trails it.
      pe_en    <= rd_en;
      case (state)
        S_IDLE: begin
          if (start && (cfg_len != '0)) begin
            state    <= S_FETCH;
            busy     <= 1'b1;
            rd_en    <= 1'b1;
            pe_clear <= 1'b1;
            ifm_addr <= cfg_ifm_base;
            wgt_addr <= cfg_wgt_base;
            remain   <= cfg_len;
            shift_q  <= cfg_shift;
          end
        end
        S_FETCH: begin
          if (remain == LEN_W'(1)) begin
            rd_en <= 1'b0;
            state <= S_WAIT;
          end else begin
            remain   <= remain - LEN_W'(1);
            ifm_addr <= ifm_addr + ADDR_W'(1);
            wgt_addr <= wgt_addr + ADDR_W'(1);
          end
        end
        S_WAIT: state <= S_CAPTURE;
        S_CAPTURE: begin
          ofm_data  <= quant;
          ofm_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (ofm_ready) begin
            ofm_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// Randomized bench for pe_mac_sequencer: per-cycle expectations come from the job timeline
// and an arithmetic requantization model; OFM results go through an expected queue.
module tb_pe_mac_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] cfg_len;
  logic [9:0] cfg_ifm_base;
  logic [9:0] cfg_wgt_base;
  logic [3:0] cfg_shift;
  logic       busy;
  logic       rd_en;
  logic [9:0] ifm_addr;
  logic [9:0] wgt_addr;
  logic       pe_clear;
  logic       pe_en;
  logic [19:0] pe_acc;
  logic [7:0] ofm_data;
  logic       ofm_valid;
  logic       ofm_ready;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  pe_mac_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len),
    .cfg_ifm_base(cfg_ifm_base), .cfg_wgt_base(cfg_wgt_base), .cfg_shift(cfg_shift),
    .busy(busy), .rd_en(rd_en), .ifm_addr(ifm_addr), .wgt_addr(wgt_addr),
    .pe_clear(pe_clear), .pe_en(pe_en), .pe_acc(pe_acc), .ofm_data(ofm_data),
    .ofm_valid(ofm_valid), .ofm_ready(ofm_ready), .done(done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Round-half-up, floor-divide by 2^sh, clamp to int8, optional ReLU.
  function automatic logic [7:0] ref_quant(input int acc, input int sh);
    longint d, r, q;
    d = longint'(1) << sh;
    r = longint'(acc) + ((sh > 0) ? d / 2 : longint'(0));
    q = r / d;
    if ((r % d != 0) && (r < 0)) q = q - 1;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
`ifdef PE_SEQ_RELU_EN
    if (q < 0) q = 0;
`endif
    return q[7:0];
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      32'(busy), 32'(0));
    check({tag, "_rd_en"},     32'(rd_en), 32'(0));
    check({tag, "_pe_clear"},  32'(pe_clear), 32'(0));
    check({tag, "_pe_en"},     32'(pe_en), 32'(0));
    check({tag, "_ofm_valid"}, 32'(ofm_valid), 32'(0));
    check({tag, "_done"},      32'(done), 32'(0));
    check({tag, "_ifm_addr"},  32'(ifm_addr), 32'(0));
    check({tag, "_wgt_addr"},  32'(wgt_addr), 32'(0));
    check({tag, "_ofm_data"},  32'(ofm_data), 32'(0));
  endtask

  // ---------------- drivers ----------------
  // Idle cycles; start pulses carry cfg_len=0 and must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      start     = 1'($urandom_range(0, 1));
      cfg_len   = '0;
      pe_acc    = 20'($urandom);
      ofm_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'(0));
      check("idle_rd_en", 32'(rd_en), 32'(0));
      check("idle_pe_en", 32'(pe_en), 32'(0));
      check("idle_valid", 32'(ofm_valid), 32'(0));
      check("idle_done", 32'(done), 32'(0));
    end
  endtask

  // Entered in cycle 0 (before its closing edge); returns at the negedge of the done cycle.
  task automatic run_job(input int len, input int ib, input int wb, input int sh,
                         input int acc, input int delay);
    int h;
    h = len + 3 + delay;
    exp_q.push_back(ref_quant(acc, sh));
    start        = 1'b1;
    cfg_len      = 10'(len);
    cfg_ifm_base = 10'(ib);
    cfg_wgt_base = 10'(wb);
    cfg_shift    = 4'(sh);
    step();
    for (int k = 1; k <= h + 1; k++) begin
      // Config and start churn during the job must not disturb it.
      start        = (k <= h) ? 1'($urandom_range(0, 1)) : 1'b0;
      cfg_len      = 10'($urandom);
      cfg_ifm_base = 10'($urandom);
      cfg_wgt_base = 10'($urandom);
      cfg_shift    = 4'($urandom);
      pe_acc       = (k == len + 2) ? 20'(acc) : 20'($urandom);
      if (k < len + 3)  ofm_ready = 1'($urandom_range(0, 1));
      else if (k < h)   ofm_ready = 1'b0;
      else if (k == h)  ofm_ready = 1'b1;
      else              ofm_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("busy", 32'(busy), 32'(k <= h));
      check("rd_en", 32'(rd_en), 32'(k <= len));
      check("pe_clear", 32'(pe_clear), 32'(k == 1));
      check("pe_en", 32'(pe_en), 32'((k >= 2) && (k <= len + 1)));
      check("ofm_valid", 32'(ofm_valid), 32'((k >= len + 3) && (k <= h)));
      check("done", 32'(done), 32'(k == h + 1));
      if (k <= len) begin
        check("ifm_addr", 32'(ifm_addr), 32'((ib + k - 1) % 1024));
        check("wgt_addr", 32'(wgt_addr), 32'((wb + k - 1) % 1024));
      end
      if ((k >= len + 3) && (k <= h) && (exp_q.size() > 0)) begin
        check("ofm_data", 32'(ofm_data), 32'(exp_q[0]));
        if (k == h) void'(exp_q.pop_front());
      end
      if (k <= h) step();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int len, acc;
    reset = 1'b1; start = 1'b0; cfg_len = '0; cfg_ifm_base = '0; cfg_wgt_base = '0;
    cfg_shift = '0; pe_acc = '0; ofm_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("rst");
    reset = 1'b0;
    idle(2);

    // Basic job, then directed requantization corners back to back.
    run_job(4, 'h010, 'h200, 0, 37, 0);
    check("basic_value", 32'(ofm_data), 32'(37));
    run_job(3, 'h100, 'h080, 1, 5, 0);
    run_job(2, 'h001, 'h002, 1, -5, 0);
    run_job(5, 'h033, 'h044, 2, 1000, 0);
    run_job(6, 'h055, 'h066, 0, -3000, 0);
    run_job(2, 0, 0, 15, 524287, 1);
    run_job(2, 0, 0, 15, -524288, 0);
    idle(2);

    // Backpressure, address wrap, single-term job.
    run_job(7, 'h123, 'h321, 3, -777, 5);
    idle(1);
    run_job(4, 'h3FE, 'h3FE, 0, 12, 0);
    run_job(1, 'h2AA, 'h155, 4, 300, 0);
    idle(3);

    // Asynchronous reset in cycle 3 of an L=8 job.
    start = 1'b1; cfg_len = 10'd8; cfg_ifm_base = 10'h040; cfg_wgt_base = 10'h050; cfg_shift = '0;
    step();
    start = 1'b0;
    step();
    step();
    #2 reset = 1'b1;
    #1 check_all_zero("mid_rst");
    @(negedge clk);
    check_all_zero("mid_rst_hold");
    reset = 1'b0;
    idle(3);
    run_job(8, 'h040, 'h050, 2, 4096, 0);

    // Randomized jobs, including the maximum length once.
    for (int j = 0; j < 40; j++) begin
      len = (j == 20) ? 1023 : int'($urandom_range(1, 20));
      acc = int'($urandom_range(0, 1048575)) - 524288;
      if (j % 4 == 0) acc = int'($urandom_range(0, 600)) - 300;
      run_job(len, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
              int'($urandom_range(0, 15)), acc, int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
    check("exp_q_empty", 32'(exp_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
